// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider producing one quotient bit per clock.
// Each trial subtraction is an add of the inverted divisor with carry-in 1,
// matching the add/sub convention of the neighbouring ripple adder.
// Control is a start/busy/done handshake. A zero divisor short-circuits
// straight to DONE with quotient all ones and remainder equal to the dividend.
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   r_shift_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   r_next_s;
  logic [WIDTH-1:0] q_next_s;
  logic             no_borrow_s;
  logic             last_s;
  logic             divisor_zero_s;

  // One restoring step: shift, trial-subtract via inverted add, keep or restore.
  always_comb begin
    r_shift_s      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial_s        = r_shift_s + ~{1'b0, divisor_q} + {{WIDTH{1'b0}}, 1'b1};
    no_borrow_s    = ~trial_s[WIDTH];
    r_next_s       = no_borrow_s ? trial_s : r_shift_s;
    q_next_s       = {q_q[WIDTH-2:0], no_borrow_s};
    last_s         = (cnt_q == CW'(WIDTH - 1));
    divisor_zero_s = (divisor == {WIDTH{1'b0}});
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CW{1'b0}};
      q_q         <= {WIDTH{1'b0}};
      r_q         <= {(WIDTH+1){1'b0}};
      divisor_q   <= {WIDTH{1'b0}};
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      r_q         <= r_d;
      divisor_q   <= divisor_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = divisor_zero_s ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (last_s) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values: operand capture, iteration, and result load.
  always_comb begin
    cnt_d       = cnt_q;
    q_d         = q_q;
    r_d         = r_q;
    divisor_d   = divisor_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          divisor_d = divisor;
          cnt_d     = {CW{1'b0}};
          q_d       = dividend;
          r_d       = {(WIDTH+1){1'b0}};
          if (divisor_zero_s) begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            dbz_d = dbz_q;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        q_d   = q_next_s;
        r_d   = r_next_s;
        if (last_s) begin
          quotient_d  = q_next_s;
          remainder_d = r_next_s[WIDTH-1:0];
          dbz_d       = 1'b0;
        end else begin
          dbz_d = dbz_q;
        end
      end
      default: begin
        cnt_d = {CW{1'b0}};
      end
    endcase
  end

  // Handshake outputs decode directly from the state register.
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Scoreboard bench for restoring_divider at WIDTH=4 (directed + exhaustive)
// and WIDTH=8 (random sweep). Expected results are queued at issue time and
// compared, together with the done-cycle timing, when done is seen.
module tb_restoring_divider;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start4 = 1'b0;
  logic [3:0] dvd4 = 4'd0, dvs4 = 4'd0;
  logic       busy4, done4, dbz4;
  logic [3:0] quot4, rem4;

  logic       start8 = 1'b0;
  logic [7:0] dvd8 = 8'd0, dvs8 = 8'd0;
  logic       busy8, done8, dbz8;
  logic [7:0] quot8, rem8;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb4[$];
  exp_t sb8[$];
  logic [7:0] last4_q = 8'd0, last4_r = 8'd0;
  logic [7:0] last8_q = 8'd0, last8_r = 8'd0;

  restoring_divider #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .dividend(dvd4), .divisor(dvs4),
    .busy(busy4), .done(done4), .quotient(quot4), .remainder(rem4),
    .div_by_zero(dbz4)
  );

  restoring_divider #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .dividend(dvd8), .divisor(dvs8),
    .busy(busy8), .done(done8), .quotient(quot8), .remainder(rem8),
    .div_by_zero(dbz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference result for a WIDTH-bit divide.
  function automatic exp_t model(input int a, input int b, input int w, input int c);
    exp_t e;
    if (b == 0) begin
      e.q   = 8'((1 << w) - 1);
      e.r   = 8'(a);
      e.dbz = 1'b1;
      e.cyc = c + 1;
    end else begin
      e.q   = 8'(a / b);
      e.r   = 8'(a % b);
      e.dbz = 1'b0;
      e.cyc = c + 1 + w;
    end
    return e;
  endfunction

  task automatic issue4(input int a, input int b);
    int n;
    n = 0;
    while (busy4 === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("issue4_timeout", 32'd1, 32'd0);
    start4 = 1'b1;
    dvd4   = 4'(a);
    dvs4   = 4'(b);
    sb4.push_back(model(a, b, 4, cyc));
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic issue8(input int a, input int b);
    int n;
    n = 0;
    while (busy8 === 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("issue8_timeout", 32'd1, 32'd0);
    start8 = 1'b1;
    dvd8   = 8'(a);
    dvs8   = 8'(b);
    sb8.push_back(model(a, b, 8, cyc));
    @(negedge clk);
    start8 = 1'b0;
  endtask

  // WIDTH=4 monitor: score results on done, check outputs hold while busy.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done4) begin
        check("busy4_in_done", 32'(busy4), 32'd0);
        if (sb4.size() == 0) begin
          check("spurious_done4", 32'd1, 32'd0);
        end else begin
          e = sb4.pop_front();
          check("quot4", 32'(quot4), 32'(e.q));
          check("rem4", 32'(rem4), 32'(e.r));
          check("dbz4", 32'(dbz4), 32'(e.dbz));
          check("lat4", 32'(cyc), 32'(e.cyc));
          last4_q = e.q;
          last4_r = e.r;
        end
      end else if (busy4) begin
        check("hold_q4", 32'(quot4), 32'(last4_q));
        check("hold_r4", 32'(rem4), 32'(last4_r));
      end
    end
  end

  // WIDTH=8 monitor.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done8) begin
        if (sb8.size() == 0) begin
          check("spurious_done8", 32'd1, 32'd0);
        end else begin
          e = sb8.pop_front();
          check("quot8", 32'(quot8), 32'(e.q));
          check("rem8", 32'(rem8), 32'(e.r));
          check("dbz8", 32'(dbz8), 32'(e.dbz));
          check("lat8", 32'(cyc), 32'(e.cyc));
          last8_q = e.q;
          last8_r = e.r;
        end
      end else if (busy8) begin
        check("hold_q8", 32'(quot8), 32'(last8_q));
        check("hold_r8", 32'(rem8), 32'(last8_r));
      end
    end
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_done", 32'(done4), 32'd0);
    check("rst_quot", 32'(quot4), 32'd0);
    check("rst_rem", 32'(rem4), 32'd0);
    check("rst_dbz", 32'(dbz4), 32'd0);
    check("rst_quot8", 32'(quot8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and edge operands.
    issue4(13, 4);
    issue4(15, 1);
    issue4(3, 7);
    issue4(0, 5);
    issue4(15, 15);
    // Divide by zero, then a normal divide clears the flag.
    issue4(9, 0);
    issue4(8, 2);

    // Start while busy is ignored; start in the done cycle is accepted.
    issue4(13, 4);
    start4 = 1'b1;
    dvd4   = 4'd15;
    dvs4   = 4'd1;
    @(negedge clk);
    start4 = 1'b0;
    issue4(10, 3);

    // Reset during RUN aborts with no done pulse.
    issue4(14, 3);
    @(negedge clk);
    rst_n = 1'b0;
    sb4.delete();
    @(negedge clk);
    check("abort_busy", 32'(busy4), 32'd0);
    check("abort_done", 32'(done4), 32'd0);
    check("abort_quot", 32'(quot4), 32'd0);
    check("abort_rem", 32'(rem4), 32'd0);
    check("abort_dbz", 32'(dbz4), 32'd0);
    last4_q = 8'd0;
    last4_r = 8'd0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    issue4(14, 3);

    // Exhaustive WIDTH=4, back-to-back.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        issue4(a, b);
      end
    end

    // Random sweep at WIDTH=8 plus boundary divisors.
    issue8(255, 1);
    issue8(255, 255);
    issue8(200, 0);
    issue8(7, 200);
    for (int i = 0; i < 150; i++) begin
      issue8(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    n = 0;
    while ((sb4.size() != 0 || sb8.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain4", 32'(sb4.size()), 32'd0);
    check("drain8", 32'(sb8.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
